dm_ctrl: RTL and testbench

Parametrised, multi-cycle successor to the single-cycle data-memory/writeback stage of the scmips core. It is byte-addressed and big-endian, and supports word, halfword and byte loads and stores with sign or zero extension. Array latency is configurable and covered by a Stall handshake toward the pipeline. It also flags misaligned accesses, and it keeps the existing writeback selection (load data, link address for JAL/JALR, ALU result otherwise).

---
 rtl/dm_ctrl_pkg.sv | 45 ++++
 rtl/dm_ctrl_align.sv | 60 ++++++
 rtl/dm_ctrl.sv | 139 +++++++++++++
 tb/tb_dm_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_ctrl_pkg.sv
// Shared opcodes, FSM states and decode helpers for the multi-cycle data-memory stage.
package dm_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JALR  = 6'h09;

  localparam int DMEM_DEPTH_DEF = 1024;
  localparam int LAT_DEF        = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic is_load(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
           (op == OP_LBU) || (op == OP_LHU);
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic is_misaligned(input logic [5:0] op, input logic [1:0] lane);
    logic mis;
    mis = 1'b0;
    case (op)
      OP_LW, OP_SW:          mis = (lane != 2'b00);
      OP_LH, OP_LHU, OP_SH:  mis = lane[0];
      default:               mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dm_ctrl_align.sv
// Big-endian lane handling: load extraction/extension and store byte-lane merge.
module dm_align
  import dm_ctrl_pkg::*;
(
  input  logic [5:0]  i_op,
  input  logic [1:0]  i_lane,
  input  logic [31:0] i_rword,
  input  logic [31:0] i_sdata,
  output logic [31:0] o_ldata,
  output logic [31:0] o_mword
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane 0 is the most significant byte.
  always_comb begin
    w_byte = i_rword[31:24];
    case (i_lane)
      2'd0: w_byte = i_rword[31:24];
      2'd1: w_byte = i_rword[23:16];
      2'd2: w_byte = i_rword[15:8];
      2'd3: w_byte = i_rword[7:0];
      default: w_byte = i_rword[31:24];
    endcase
    w_half = i_lane[1] ? i_rword[15:0] : i_rword[31:16];
  end

  always_comb begin
    o_ldata = i_rword;
    case (i_op)
      OP_LB:   o_ldata = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  o_ldata = {24'h0, w_byte};
      OP_LH:   o_ldata = {{16{w_half[15]}}, w_half};
      OP_LHU:  o_ldata = {16'h0, w_half};
      default: o_ldata = i_rword;
    endcase
  end

  always_comb begin
    o_mword = i_rword;
    case (i_op)
      OP_SB: begin
        case (i_lane)
          2'd0: o_mword[31:24] = i_sdata[7:0];
          2'd1: o_mword[23:16] = i_sdata[7:0];
          2'd2: o_mword[15:8]  = i_sdata[7:0];
          2'd3: o_mword[7:0]   = i_sdata[7:0];
          default: o_mword = i_rword;
        endcase
      end
      OP_SH: begin
        if (i_lane[1]) o_mword[15:0]  = i_sdata[15:0];
        else           o_mword[31:16] = i_sdata[15:0];
      end
      default: o_mword = i_sdata;
    endcase
  end

endmodule

// File: rtl/dm_ctrl.sv
// Multi-cycle data-memory / writeback stage: array with configurable latency,
// stall handshake, misalignment rejection and writeback select.
module dm_ctrl
  import dm_ctrl_pkg::*;
#(
  parameter  int DMEM_DEPTH = DMEM_DEPTH_DEF,
  parameter  int LAT        = LAT_DEF,
  localparam int AW         = $clog2(DMEM_DEPTH)
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        Valid,
  input  logic [31:0] Ins,
  input  logic [31:0] Result,
  input  logic [31:0] Rdata2,
  input  logic [31:0] nextPC,
  output logic [31:0] Wdata,
  output logic        Wvalid,
  output logic        Stall,
  output logic        Misalign
);

  // state  | meaning
  // S_IDLE | pass-through; accepts an aligned memory op (Stall high that cycle)
  // S_BUSY | array access in flight, cnt counts down to the commit edge
  // S_DONE | one-cycle result: Wvalid high, Stall low

  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [5:0]      r_op;
  logic [31:0]     r_addr;
  logic [31:0]     r_sdata;
  logic [31:0]     r_rdata;
  logic [31:0]     r_mem [DMEM_DEPTH];

  logic [5:0]      w_op;
  logic [5:0]      w_fn;
  logic            w_memop;
  logic            w_mis;
  logic            w_link;
  logic            w_accept;
  logic            w_commit;
  logic [AW-1:0]   w_idx;
  logic [1:0]      w_lane;
  logic [31:0]     w_ldata;
  logic [31:0]     w_mword;
  logic            w_unused_ins;

  assign w_op         = Ins[31:26];
  assign w_fn         = Ins[5:0];
  assign w_unused_ins = ^Ins[25:6];
  assign w_memop      = is_load(w_op) | is_store(w_op);
  assign w_mis        = is_misaligned(w_op, Result[1:0]);
  assign w_link       = (w_op == OP_JAL) || ((w_op == OP_RTYPE) && (w_fn == FN_JALR));
  assign w_accept     = (r_state == S_IDLE) && Valid && w_memop && !w_mis;
  assign w_idx        = r_addr[AW+1:2];
  assign w_lane       = r_addr[1:0];
  assign w_commit     = (r_state == S_BUSY) && (r_cnt == '0);

  dm_align u_align (
    .i_op    (r_op),
    .i_lane  (w_lane),
    .i_rword (w_commit ? r_mem[w_idx] : r_rdata),
    .i_sdata (r_sdata),
    .o_ldata (w_ldata),
    .o_mword (w_mword)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_op    <= '0;
      r_addr  <= '0;
      r_sdata <= '0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state <= S_BUSY;
            r_cnt   <= CW'(LAT - 1);
            r_op    <= w_op;
            r_addr  <= Result;
            r_sdata <= Rdata2;
          end
        end
        S_BUSY: begin
          if (r_cnt == '0) begin
            r_state <= S_DONE;
            if (is_load(r_op)) r_rdata <= r_mem[w_idx];
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Array has no reset; an abandoned store never reaches its commit edge.
  always_ff @(posedge CLK) begin
    if (RST_N && w_commit && is_store(r_op)) r_mem[w_idx] <= w_mword;
  end

  always_comb begin
    Wdata    = '0;
    Wvalid   = 1'b0;
    Stall    = 1'b0;
    Misalign = 1'b0;
    if (RST_N) begin
      case (r_state)
        S_IDLE: begin
          if (Valid && w_memop) begin
            if (w_mis) begin
              Misalign = 1'b1;
              Wvalid   = 1'b1;
            end else begin
              Stall = 1'b1;
            end
          end else begin
            Wvalid = Valid;
            Wdata  = w_link ? nextPC : Result;
          end
        end
        S_BUSY: Stall = 1'b1;
        S_DONE: begin
          Wvalid = 1'b1;
          Wdata  = is_load(r_op) ? w_ldata : r_addr;
        end
        default: Stall = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_ctrl.sv
// Scoreboard bench for dm_ctrl: byte-array reference model, randomized ops,
// directed lane/wrap/reset scenarios.
module tb_dm_ctrl;

  localparam int DEPTH  = 16;
  localparam int LAT    = 3;
  localparam int NBYTES = DEPTH * 4;

  localparam logic [5:0] LB  = 6'h20, LH  = 6'h21, LW  = 6'h23, LBU = 6'h24;
  localparam logic [5:0] LHU = 6'h25, SB  = 6'h28, SH  = 6'h29, SW  = 6'h2B;
  localparam logic [5:0] JAL = 6'h03, RTY = 6'h00;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic [31:0] ins = '0, result = '0, rdata2 = '0, npc = '0;
  logic [31:0] wdata;
  logic        wvalid, stall, misalign;

  typedef struct {
    logic [31:0] d;
    logic        m;
    string       tag;
  } exp_t;

  exp_t        q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [7:0]  mb [NBYTES];

  dm_ctrl #(.DMEM_DEPTH(DEPTH), .LAT(LAT)) dut (
    .CLK(clk), .RST_N(rst_n), .Valid(valid), .Ins(ins), .Result(result),
    .Rdata2(rdata2), .nextPC(npc), .Wdata(wdata), .Wvalid(wvalid),
    .Stall(stall), .Misalign(misalign)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rd_bytes(input int a, input int n);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v = (v << 8) | {24'h0, mb[(a + i) % NBYTES]};
    return v;
  endfunction

  // Behavioural model: memory is a flat big-endian byte array.
  function automatic void model(input logic [5:0] op, input logic [5:0] fn,
                                input logic [31:0] res, input logic [31:0] rd2,
                                input logic [31:0] pc, output logic [31:0] d,
                                output logic m, output int lat);
    int a;
    a   = int'(res % 32'(NBYTES));
    m   = 1'b0;
    lat = LAT + 1;
    d   = res;
    case (op)
      LW:  if (a % 4 != 0) m = 1'b1; else d = rd_bytes(a, 4);
      LH, LHU: begin
        if (a % 2 != 0) m = 1'b1;
        else begin
          d = rd_bytes(a, 2);
          if (op == LH && d[15]) d = d | 32'hFFFF0000;
        end
      end
      LB, LBU: begin
        d = rd_bytes(a, 1);
        if (op == LB && d[7]) d = d | 32'hFFFFFF00;
      end
      SW: begin
        if (a % 4 != 0) m = 1'b1;
        else for (int i = 0; i < 4; i++) mb[a + i] = rd2[31 - 8*i -: 8];
      end
      SH: begin
        if (a % 2 != 0) m = 1'b1;
        else begin
          mb[a]     = rd2[15:8];
          mb[a + 1] = rd2[7:0];
        end
      end
      SB:  mb[a] = rd2[7:0];
      JAL: begin d = pc; lat = 0; end
      default: begin
        lat = 0;
        d = (op == RTY && fn == 6'h09) ? pc : res;
      end
    endcase
    if (m) begin
      d   = '0;
      lat = 0;
    end
  endfunction

  task automatic do_op(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] res,
                       input logic [31:0] rd2, input logic [31:0] pc);
    logic [31:0] d, ins_v;
    logic        m;
    int          lat, cnt;
    bit          stall_ok;
    string       tag;
    ins_v = {op, 20'($urandom), fn};
    tag   = $sformatf("op%02h@%08h", op, res);
    @(posedge clk); #1;
    valid = 1'b1; ins = ins_v; result = res; rdata2 = rd2; npc = pc;
    model(op, fn, res, rd2, pc, d, m, lat);
    q.push_back('{d, m, tag});
    cnt = 0;
    stall_ok = 1'b1;
    forever begin
      @(negedge clk);
      if (wvalid) begin
        if (stall) stall_ok = 1'b0;
        break;
      end
      if (!stall) stall_ok = 1'b0;
      // Latched copies must be used while busy; scramble the held inputs.
      if (cnt >= 1 && cnt < LAT) begin
        ins = $urandom; result = $urandom; rdata2 = $urandom;
      end else if (cnt == LAT) begin
        ins = ins_v; result = res; rdata2 = rd2;
      end
      cnt++;
      if (cnt > 40) begin
        n_cmp++; n_err++;
        $display("FAIL timeout %s: no Wvalid after %0d cycles, want %0d", tag, cnt, lat);
        break;
      end
    end
    n_cmp++;
    if (cnt != lat || !stall_ok) begin
      n_err++;
      $display("FAIL latency %s: got %0d cycles stall_ok=%0b, want %0d cycles with Stall until Wvalid",
               tag, cnt, stall_ok, lat);
    end
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    valid = 1'b0; ins = $urandom; result = $urandom;
    @(negedge clk);
    n_cmp++;
    if (wvalid || stall || misalign) begin
      n_err++;
      $display("FAIL idle: got wvalid=%0b stall=%0b misalign=%0b, want all 0", wvalid, stall, misalign);
    end
  endtask

  task automatic chk_zero(input string tag);
    n_cmp++;
    if (wdata !== 32'h0 || wvalid !== 1'b0 || stall !== 1'b0 || misalign !== 1'b0) begin
      n_err++;
      $display("FAIL %s: got wdata=%08h wvalid=%0b stall=%0b misalign=%0b, want all 0",
               tag, wdata, wvalid, stall, misalign);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && wvalid) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_wvalid: got wdata=%08h, want no output", wdata);
        end else begin
          e = q.pop_front();
          if (wdata !== e.d || misalign !== e.m) begin
            n_err++;
            $display("FAIL wb %s: got wdata=%08h misalign=%0b, want wdata=%08h misalign=%0b",
                     e.tag, wdata, misalign, e.d, e.m);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [5:0] ops [12];
    int         k;
    ops = '{LB, LH, LW, LBU, LHU, SB, SH, SW, JAL, RTY, RTY, 6'h08};
    for (int i = 0; i < NBYTES; i++) mb[i] = 8'h00;

    repeat (3) @(negedge clk);
    chk_zero("reset_state");
    rst_n = 1'b1;
    @(negedge clk);
    chk_zero("post_reset_idle");

    do_op(SW, 6'h00, 32'h10, 32'hDEADBEEF, 32'h0);
    do_op(LW, 6'h00, 32'h10, 32'h0, 32'h0);
    do_op(SB, 6'h00, 32'h11, 32'h0000005A, 32'h0);
    do_op(LBU, 6'h00, 32'h11, 32'h0, 32'h0);
    do_op(LB, 6'h00, 32'h10, 32'h0, 32'h0);
    do_op(LW, 6'h00, 32'h10, 32'h0, 32'h0);
    do_op(SH, 6'h00, 32'h12, 32'h00008001, 32'h0);
    do_op(LH, 6'h00, 32'h12, 32'h0, 32'h0);
    do_op(LHU, 6'h00, 32'h12, 32'h0, 32'h0);
    do_op(LH, 6'h00, 32'h13, 32'h0, 32'h0);
    do_op(SW, 6'h00, 32'h13, 32'hFFFFFFFF, 32'h0);
    do_op(LW, 6'h00, 32'h10, 32'h0, 32'h0);
    do_op(JAL, 6'h00, 32'h55, 32'h0, 32'h404);
    do_op(RTY, 6'h09, 32'h66, 32'h0, 32'h808);
    do_op(RTY, 6'h20, 32'h7, 32'h0, 32'h404);
    idle_cycle();
    do_op(SW, 6'h00, 32'h40, 32'h11111111, 32'h0);
    do_op(LW, 6'h00, 32'h00, 32'h0, 32'h0);

    // Reset during the second busy cycle abandons the store.
    @(posedge clk); #1;
    valid = 1'b1; ins = {SW, 26'h0}; result = 32'h20; rdata2 = 32'hAAAAAAAA;
    @(posedge clk);
    @(posedge clk); #2;
    n_cmp++;
    if (stall !== 1'b1) begin
      n_err++;
      $display("FAIL busy_before_reset: got stall=%0b, want 1", stall);
    end
    rst_n = 1'b0;
    #1;
    chk_zero("reset_in_busy");
    valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    do_op(LW, 6'h00, 32'h20, 32'h0, 32'h0);

    // Reset during DONE keeps the committed store.
    do_op(SW, 6'h00, 32'h24, 32'h12345678, 32'h0);
    #1;
    rst_n = 1'b0;
    #1;
    chk_zero("reset_in_done");
    valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    do_op(LW, 6'h00, 32'h24, 32'h0, 32'h0);

    for (int n = 0; n < 200; n++) begin
      k = $urandom_range(0, 11);
      do_op(ops[k], (k == 9) ? 6'h09 : 6'($urandom), $urandom, $urandom, $urandom);
      if ($urandom_range(0, 4) == 0) idle_cycle();
    end

    repeat (3) @(negedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL leftover: got %0d pending expected results, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
